// File: rtl/icebtn_io.sv
// rtl/icebtn_io.sv - debounced five-button status word at ADDR with W1C press latches and press counter
// Optional interrupt output enabled by defining ICEBTN_IRQ_EN.
module icebtn_io #(
    parameter logic [7:0]  ADDR            = 8'hFE,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd48000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  btn_in,
    input  logic [7:0]  read_address,
    input  logic [7:0]  write_address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic        read_hit,
    output logic [31:0] read_data,
    output logic        irq
);

    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       sync2_q, sync2_d;
    logic [4:0][15:0] cnt_q, cnt_d;
    logic [4:0]       lvl_q, lvl_d;
    logic [4:0]       pressed_q, pressed_d;
    logic [7:0]       count_q, count_d;
    logic [4:0]       rise;
    logic [4:0]       clr_mask;
    logic [7:0]       inc;
    logic             store_hit;
    logic             unused_write_bits;

    assign unused_write_bits = ^{write_data[30:13], write_data[7:0]};

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
                cnt_d[i] = 16'd0;
            end else if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                lvl_d[i] = sync2_q[i];
                cnt_d[i] = 16'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Clear is applied before the new rises so a coincident press wins.
    always_comb begin
        rise      = lvl_d & ~lvl_q;
        store_hit = write_enable && (write_address == ADDR);
        clr_mask  = store_hit ? write_data[12:8] : 5'b0;
        pressed_d = (pressed_q & ~clr_mask) | rise;
        inc       = 8'd0;
        for (int i = 0; i < 5; i++) begin
            inc = inc + {7'd0, rise[i]};
        end
        count_d = ((store_hit && write_data[31]) ? 8'd0 : count_q) + inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 5'd0;
            sync2_q   <= 5'd0;
            cnt_q     <= '0;
            lvl_q     <= 5'd0;
            pressed_q <= 5'd0;
            count_q   <= 8'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            pressed_q <= pressed_d;
            count_q   <= count_d;
        end
    end

`ifdef ICEBTN_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = |pressed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        read_hit  = (read_address == ADDR);
        read_data = 32'd0;
        if (read_hit) begin
            read_data = {8'd0, count_q, 3'd0, pressed_q, 3'd0, lvl_q};
        end
    end

endmodule
